// File: rtl/formula_pipe_result_sink_if.sv
// Handshake bundle between issuer, formula pipe and downstream consumer for formula_pipe_result_sink.
interface formula_pipe_result_sink_if #(
  parameter int WIDTH = 32
);
  logic             up_vld;
  logic             up_rdy;
  logic             arg_vld;
  logic             res_vld;
  logic [WIDTH-1:0] res;
  logic             down_vld;
  logic [WIDTH-1:0] down_data;
  logic             down_rdy;
  logic             err;

  modport slave (
    input  up_vld, res_vld, res, down_rdy,
    output up_rdy, arg_vld, down_vld, down_data, err
  );

  modport master (
    output up_vld, res_vld, res, down_rdy,
    input  up_rdy, arg_vld, down_vld, down_data, err
  );
endinterface

// File: rtl/formula_pipe_result_sink.sv
// Credit-gated result FIFO behind a fixed-latency valid-only pipe, with valid/ready egress.
// Optional arrival-time checker: define FORMULA_PIPE_RESULT_SINK_LATENCY_CHECK_EN.
module formula_pipe_result_sink #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8
) (
  input logic                       clk,
  input logic                       rst,
  formula_pipe_result_sink_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int FW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]    count, reserved, reserved_nxt;
  logic [FW-1:0]    in_flight;
  logic             up_rdy_q, err_q, head_ld;
  logic [WIDTH-1:0] head_q, head_d;
  logic             issue, pop, push, full, overflow, unexpected, lat_err, dec;

  assign issue       = bus.up_vld & up_rdy_q;
  assign bus.arg_vld = issue;
  assign bus.up_rdy  = up_rdy_q;
  assign bus.down_vld  = (count != '0);
  assign bus.down_data = head_q;
  assign bus.err       = err_q;

  assign pop        = bus.down_vld & bus.down_rdy;
  assign full       = (count == DEPTH_C);
  assign push       = bus.res_vld & (~full | pop);
  assign overflow   = bus.res_vld & full & ~pop;
  assign unexpected = bus.res_vld & (in_flight == '0);
  assign dec        = bus.res_vld & (in_flight != '0);
  assign rd_ptr_nxt = rd_ptr + AW'(1);

  // Credits: taken on issue, returned only when the consumer retires the entry.
  always_comb begin
    reserved_nxt = reserved;
    if (issue && !pop)                        reserved_nxt = reserved + ONE_C;
    else if (!issue && pop && reserved != '0) reserved_nxt = reserved - ONE_C;
  end

  // Head register only reloads when the visible head actually changes.
  always_comb begin
    head_ld = 1'b0;
    head_d  = head_q;
    if (pop && count > ONE_C) begin
      head_ld = 1'b1;
      head_d  = mem[rd_ptr_nxt];
    end else if (push && (count == '0 || (pop && count == ONE_C))) begin
      head_ld = 1'b1;
      head_d  = bus.res;
    end
  end

`ifdef FORMULA_PIPE_RESULT_SINK_LATENCY_CHECK_EN
  logic [LATENCY-1:0] lat_sr;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lat_sr <= '0;
    else begin
      lat_sr[0] <= issue;
      for (int i = 1; i < LATENCY; i++) lat_sr[i] <= lat_sr[i-1];
    end
  end
  assign lat_err = bus.res_vld ^ lat_sr[LATENCY-1];
`else
  assign lat_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.res;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      reserved  <= '0;
      in_flight <= '0;
      up_rdy_q  <= 1'b0;
      err_q     <= 1'b0;
      head_q    <= '0;
    end else begin
      reserved <= reserved_nxt;
      up_rdy_q <= (reserved_nxt < DEPTH_C);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_nxt;
      if (push && !pop)      count <= count + ONE_C;
      else if (pop && !push) count <= count - ONE_C;
      if (issue && !dec)      in_flight <= in_flight + FW'(1);
      else if (!issue && dec) in_flight <= in_flight - FW'(1);
      if (head_ld) head_q <= head_d;
      if (overflow || unexpected || lat_err) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_formula_pipe_result_sink.sv
// Scoreboard bench: a model pipe returns the issue index after LATENCY cycles; popped data is checked in order.
module tb_formula_pipe_result_sink;
  localparam int W = 32;
  localparam int L = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  formula_pipe_result_sink_if #(.WIDTH(W)) bus ();
  formula_pipe_result_sink #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  logic         up_vld = 1'b0, down_rdy = 1'b0, inj = 1'b0, sup = 1'b0;
  logic [W-1:0] inj_dat = '0;
  logic [L-1:0] pv = '0;
  logic [W-1:0] pd [L];
  int unsigned  issue_idx = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] got_q [$];
  int           stored = 0, max_stored = 0;
  int           checks = 0, errors = 0;

  assign bus.up_vld   = up_vld;
  assign bus.down_rdy = down_rdy;
  assign bus.res_vld  = (pv[L-1] & ~sup) | inj;
  assign bus.res      = inj ? inj_dat : pd[L-1];

  // Model pipe plus scoreboard capture; cleared by the shared reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pv <= '0;
      for (int i = 0; i < L; i++) pd[i] <= '0;
      exp_q.delete();
      got_q.delete();
      stored = 0;
    end else begin
      pv    <= {pv[L-2:0], bus.arg_vld};
      pd[0] <= W'(issue_idx);
      for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
      if (bus.arg_vld) begin
        exp_q.push_back(W'(issue_idx));
        issue_idx++;
      end
      if (bus.res_vld && (stored < D || (bus.down_vld && bus.down_rdy))) stored++;
      if (bus.down_vld && bus.down_rdy) begin
        got_q.push_back(bus.down_data);
        stored--;
      end
      if (stored > max_stored) max_stored = stored;
    end
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0; up_vld = 1'b1; inj = 1'b1; inj_dat = '1; down_rdy = 1'b1; sup = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.up_rdy, bus.arg_vld, bus.down_vld, bus.err} !== 4'b0 || bus.down_data !== '0)
        begin errors++; $display("FAIL reset_outputs: got rdy/arg/vld/err=%b data=%0h required 0000/0",
          {bus.up_rdy, bus.arg_vld, bus.down_vld, bus.err}, bus.down_data); end
    end
    up_vld = 1'b0; inj = 1'b0; down_rdy = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL reset_release_rdy: got %b required 1", bus.up_rdy); end
  endtask

  task automatic test_full_rate();
    int n = 0, drop = 0, guard = 0;
    logic [W-1:0] g, e;
    down_rdy = 1'b1;
    while (n < 50 && guard < 200) begin
      @(negedge clk); up_vld = 1'b1; #1;
      if (!bus.up_rdy) drop++;
      if (bus.arg_vld) n++;
      guard++;
    end
    @(negedge clk); up_vld = 1'b0;
    repeat (L + 4) @(negedge clk);
    checks++;
    if (n != 50 || drop != 0) begin errors++; $display("FAIL full_rate_issue: got %0d issues %0d stalls required 50 issues 0 stalls", n, drop); end
    checks++;
    if (got_q.size() != 50) begin errors++; $display("FAIL full_rate_count: got %0d required 50", got_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL full_rate_data: got %0h required %0h", g, e); end
    end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL full_rate_err: got %b required 0", bus.err); end
  endtask

  task automatic test_backpressure();
    int n = 0;
    logic [W-1:0] g, e;
    down_rdy = 1'b0;
    repeat (12) begin
      @(negedge clk); up_vld = 1'b1; #1;
      if (bus.arg_vld) n++;
    end
    checks++;
    if (n != D || bus.up_rdy !== 1'b0) begin errors++; $display("FAIL bp_issue: got %0d issues rdy=%b required %0d rdy=0", n, bus.up_rdy, D); end
    @(negedge clk); up_vld = 1'b0;
    repeat (L + 2) @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || bus.down_vld !== 1'b1 || stored != D)
      begin errors++; $display("FAIL bp_landed: got err=%b vld=%b stored=%0d required 0/1/%0d", bus.err, bus.down_vld, stored, D); end
    @(negedge clk); down_rdy = 1'b1; #1;
    checks++;
    if (bus.up_rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy_before_pop: got %b required 0", bus.up_rdy); end
    @(negedge clk);
    checks++;
    if (bus.up_rdy !== 1'b1) begin errors++; $display("FAIL bp_rdy_after_pop: got %b required 1", bus.up_rdy); end
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() != D) begin errors++; $display("FAIL bp_drain_count: got %0d required %0d", got_q.size(), D); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL bp_data: got %0h required %0h", g, e); end
    end
  endtask

  task automatic test_wrap();
    int n = 0, guard = 0;
    logic tog = 1'b0;
    logic [W-1:0] g, e;
    max_stored = 0;
    while (n < 20 && guard < 400) begin
      @(negedge clk); tog = ~tog; down_rdy = tog; up_vld = 1'b1; #1;
      if (bus.arg_vld) n++;
      guard++;
    end
    @(negedge clk); up_vld = 1'b0;
    repeat (40) begin @(negedge clk); tog = ~tog; down_rdy = tog; end
    down_rdy = 1'b0;
    checks++;
    if (n != 20 || got_q.size() != 20) begin errors++; $display("FAIL wrap_count: got %0d issued %0d popped required 20", n, got_q.size()); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_data: got %0h required %0h", g, e); end
    end
    checks++;
    if (max_stored > D || bus.err !== 1'b0) begin errors++; $display("FAIL wrap_occupancy: got max=%0d err=%b required <=%0d 0", max_stored, bus.err, D); end
  endtask

  task automatic test_unexpected();
    test_reset();
    @(negedge clk); inj = 1'b1; inj_dat = 32'hDEAD_BEEF;
    @(negedge clk); inj = 1'b0;
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL unexp_err: got %b required 1", bus.err); end
    checks++;
    if (bus.down_vld !== 1'b1 || bus.down_data !== 32'hDEAD_BEEF)
      begin errors++; $display("FAIL unexp_push: got vld=%b data=%0h required 1 deadbeef", bus.down_vld, bus.down_data); end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL unexp_sticky: got %b required 1", bus.err); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] g, e, head;
    test_reset();
    repeat (D) begin @(negedge clk); up_vld = 1'b1; end
    @(negedge clk); up_vld = 1'b0;
    repeat (L + 2) @(negedge clk);
    checks++;
    if (bus.err !== 1'b0 || stored != D) begin errors++; $display("FAIL ovf_fill: got err=%b stored=%0d required 0 %0d", bus.err, stored, D); end
    head = exp_q[0];
    @(negedge clk); inj = 1'b1; inj_dat = 32'h0000_0BAD;
    @(negedge clk); inj = 1'b0;
    checks++;
    if (bus.err !== 1'b1 || bus.down_data !== head) begin errors++; $display("FAIL ovf_err: got err=%b head=%0h required 1 %0h", bus.err, bus.down_data, head); end
    down_rdy = 1'b1;
    repeat (12) @(negedge clk);
    down_rdy = 1'b0;
    checks++;
    if (got_q.size() != D) begin errors++; $display("FAIL ovf_drop: got %0d entries required %0d", got_q.size(), D); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL ovf_data: got %0h required %0h", g, e); end
    end
  endtask

`ifdef FORMULA_PIPE_RESULT_SINK_LATENCY_CHECK_EN
  task automatic test_latency_check();
    int n = 0, guard = 0;
    logic [W-1:0] g, e;
    test_reset();
    down_rdy = 1'b1;
    while (n < 100 && guard < 2000) begin
      @(negedge clk); up_vld = 1'($urandom_range(0, 1)); #1;
      if (bus.arg_vld) n++;
      guard++;
    end
    @(negedge clk); up_vld = 1'b0;
    repeat (L + 4) @(negedge clk);
    checks++;
    if (n != 100 || bus.err !== 1'b0) begin errors++; $display("FAIL lat_ok: got %0d issues err=%b required 100 0", n, bus.err); end
    while (got_q.size() != 0 && exp_q.size() != 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL lat_data: got %0h required %0h", g, e); end
    end
    @(negedge clk); up_vld = 1'b1;
    @(negedge clk); up_vld = 1'b0;
    guard = 0;
    while (!pv[L-1] && guard < 20) begin @(negedge clk); guard++; end
    sup = 1'b1;
    @(negedge clk); sup = 1'b0; inj = 1'b1; inj_dat = pd[L-1];
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL lat_late: got %b required 1", bus.err); end
    @(negedge clk); inj = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_full_rate();
    test_backpressure();
    test_wrap();
    test_unexpected();
    test_overflow();
`ifdef FORMULA_PIPE_RESULT_SINK_LATENCY_CHECK_EN
    test_latency_check();
`endif
    test_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
